// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/ack fetch from instruction memory, instruction register.
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN.
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 32,
    parameter int                OFF_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               CLK,
    input  logic               RST_N,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    input  logic               pcSrc,
    input  logic               C_offset,
    input  logic               exec_done,
    output logic [INSTR_W-1:0] instr,
    output logic [4:0]         opcode,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [31:0]        instr_count
);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1'b1);

    state_t              state_r;
    logic [ADDR_W-1:0]   pc_r;
    logic [INSTR_W-1:0]  instr_r;
    logic                req_r;
    logic                valid_r;
    logic [ADDR_W-1:0]   next_pc_s;
    logic signed [OFF_W-1:0] offset_s;
    logic                retire_s;

    // Sign-extend the branch offset field to PC width.
    function automatic logic [ADDR_W-1:0] sext_offset(input logic signed [OFF_W-1:0] off);
        return ADDR_W'(off);
    endfunction

    assign offset_s = instr_r[OFF_W-1:0];
    assign retire_s = (state_r == ST_EXEC) && exec_done;

    // Next-PC selection; arithmetic wraps naturally at the PC width.
    always_comb begin
        next_pc_s = pc_r + PC_ONE;
        case ({pcSrc, C_offset})
            2'b00, 2'b01: next_pc_s = pc_r + PC_ONE;
            2'b10:        next_pc_s = instr_r[ADDR_W-1:0];
            2'b11:        next_pc_s = pc_r + sext_offset(offset_s);
            default:      next_pc_s = pc_r + PC_ONE;
        endcase
    end

    // Fetch/execute sequencer; req is raised one edge after reset release, then held until ack.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_FETCH;
            pc_r    <= RESET_PC;
            instr_r <= {INSTR_W{1'b1}};
            req_r   <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (!req_r) begin
                        req_r <= 1'b1;
                    end else if (imem_ack) begin
                        instr_r <= imem_rdata;
                        valid_r <= 1'b1;
                        req_r   <= 1'b0;
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        pc_r    <= next_pc_s;
                        valid_r <= 1'b0;
                        req_r   <= 1'b1;
                        state_r <= ST_FETCH;
                    end
                end
                default: begin
                    state_r <= ST_FETCH;
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef INSTR_COUNT_EN
    logic [31:0] count_r;

    // Retired-instruction counter, wraps at 2^32.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_r <= 32'd0;
        end else if (retire_s) begin
            count_r <= count_r + 32'd1;
        end
    end

    assign instr_count = count_r;
`else
    logic unused_retire_s;
    assign unused_retire_s = retire_s;
    assign instr_count     = 32'd0;
`endif

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign pc          = pc_r;
    assign instr       = instr_r;
    assign opcode      = instr_r[INSTR_W-1 -: 5];
    assign instr_valid = valid_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (counter expectation follows INSTR_COUNT_EN).
module tb_fetch_unit;

    logic        CLK;
    logic        RST_N;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        pcSrc;
    logic        C_offset;
    logic        exec_done;
    logic [31:0] instr;
    logic [4:0]  opcode;
    logic        instr_valid;
    logic [15:0] pc;
    logic [31:0] instr_count;

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .pcSrc       (pcSrc),
        .C_offset    (C_offset),
        .exec_done   (exec_done),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .pc          (pc),
        .instr_count (instr_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Zero-wait fetch: ack in the current request cycle.
    task automatic do_fetch(input string tag, input logic [31:0] data);
        imem_rdata = data;
        imem_ack   = 1'b1;
        step();
        imem_ack   = 1'b0;
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_req"},   {31'd0, imem_req},    32'd0);
        chk({tag, "_instr"}, instr,                data);
    endtask

    task automatic do_exec(input string tag, input logic src, input logic coff, input logic [15:0] exp_pc);
        pcSrc     = src;
        C_offset  = coff;
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        pcSrc     = 1'b0;
        C_offset  = 1'b0;
        chk({tag, "_addr"},  {16'd0, imem_addr},   {16'd0, exp_pc});
        chk({tag, "_pc"},    {16'd0, pc},          {16'd0, exp_pc});
        chk({tag, "_req"},   {31'd0, imem_req},    32'd1);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        int req_cycles;
        logic [31:0] exp_cnt;
        RST_N      = 1'b0;
        imem_rdata = 32'd0;
        imem_ack   = 1'b0;
        pcSrc      = 1'b0;
        C_offset   = 1'b0;
        exec_done  = 1'b0;
        step();
        step();
        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_pc",    {16'd0, pc},          32'd0);
        chk("rst_instr", instr,                32'hFFFF_FFFF);
        chk("rst_op",    {27'd0, opcode},      32'h0000_001F);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_cnt",   instr_count,          32'd0);

        // Test 1 with spurious exec_done during the wait (test 5).
        RST_N = 1'b1;
        req_cycles = 0;
        step();
        chk("t1_req_first", {31'd0, imem_req}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            if (imem_req) req_cycles++;
            exec_done = (i == 1);
            pcSrc     = (i == 1);
            step();
        end
        exec_done = 1'b0;
        pcSrc     = 1'b0;
        chk("t1_req_held", {31'd0, imem_req},  32'd1);
        chk("t1_addr",     {16'd0, imem_addr}, 32'd0);
        if (imem_req) req_cycles++;
        imem_rdata = 32'h1000_0000;
        imem_ack   = 1'b1;
        step();
        imem_ack   = 1'b0;
        chk("t1_req_cycles", req_cycles,           32'd4);
        chk("t1_instr",      instr,                32'h1000_0000);
        chk("t1_op",         {27'd0, opcode},      32'h0000_0002);
        chk("t1_valid",      {31'd0, instr_valid}, 32'd1);
        chk("t1_req_low",    {31'd0, imem_req},    32'd0);

        // Test 5: ack during EXEC is ignored.
        imem_rdata = 32'hDEAD_BEEF;
        imem_ack   = 1'b1;
        step();
        step();
        imem_ack   = 1'b0;
        chk("t5_instr", instr,                32'h1000_0000);
        chk("t5_valid", {31'd0, instr_valid}, 32'd1);
        chk("t5_req",   {31'd0, imem_req},    32'd0);
        chk("t5_pc",    {16'd0, pc},          32'd0);

        do_exec("seq0", 1'b0, 1'b0, 16'h0001);

        // Test 2: sequential from pc=5.
        do_fetch("f_j5", 32'h1800_0005);
        do_exec("jmp5", 1'b1, 1'b0, 16'h0005);
        do_fetch("f_s5", 32'h1000_0000);
        do_exec("seq6", 1'b0, 1'b1, 16'h0006);

        // exec_done held two cycles: second cycle lands in FETCH and is ignored.
        do_fetch("f_hold", 32'h1000_0000);
        exec_done = 1'b1;
        step();
        step();
        exec_done = 1'b0;
        chk("hold_pc",  {16'd0, pc},       32'h0000_0007);
        chk("hold_req", {31'd0, imem_req}, 32'd1);

        // Test 3: absolute jump.
        do_fetch("f_j40", 32'h1800_0040);
        chk("t3_op", {27'd0, opcode}, 32'h0000_0003);
        do_exec("jmp40", 1'b1, 1'b0, 16'h0040);

        // Test 4: relative branch -4 from 0x10, then same IR with pcSrc=0.
        do_fetch("f_j10a", 32'h1800_0010);
        do_exec("jmp10a", 1'b1, 1'b0, 16'h0010);
        do_fetch("f_br", 32'h2000_FFFC);
        do_exec("br_m4", 1'b1, 1'b1, 16'h000C);
        do_fetch("f_j10b", 32'h1800_0010);
        do_exec("jmp10b", 1'b1, 1'b0, 16'h0010);
        do_fetch("f_nbr", 32'h2000_FFFC);
        do_exec("nbr", 1'b0, 1'b1, 16'h0011);

        // PC wrap at all-ones, then positive relative branch.
        do_fetch("f_jff", 32'h1800_FFFF);
        do_exec("jmpff", 1'b1, 1'b0, 16'hFFFF);
        do_fetch("f_wrap", 32'h0000_0000);
        do_exec("wrap", 1'b0, 1'b0, 16'h0000);
        do_fetch("f_bp3", 32'h2000_0003);
        do_exec("br_p3", 1'b1, 1'b1, 16'h0003);

        // Test 6: async reset while awaiting ack.
        chk("t6_req_pre", {31'd0, imem_req}, 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("t6_req",   {31'd0, imem_req},    32'd0);
        chk("t6_op",    {27'd0, opcode},      32'h0000_001F);
        chk("t6_pc",    {16'd0, pc},          32'd0);
        chk("t6_valid", {31'd0, instr_valid}, 32'd0);
        chk("t6_cnt0",  instr_count,          32'd0);
        step();
        RST_N = 1'b1;
        step();
        chk("t6_restart_req",  {31'd0, imem_req},  32'd1);
        chk("t6_restart_addr", {16'd0, imem_addr}, 32'd0);
        do_fetch("r1", 32'h1000_0000);
        do_exec("r1x", 1'b0, 1'b0, 16'h0001);
        do_fetch("r2", 32'h1000_0000);
        do_exec("r2x", 1'b0, 1'b0, 16'h0002);
        do_fetch("r3", 32'h1000_0000);
        do_exec("r3x", 1'b0, 1'b0, 16'h0003);
`ifdef INSTR_COUNT_EN
        exp_cnt = 32'd3;
`else
        exp_cnt = 32'd0;
`endif
        chk("t6_cnt", instr_count, exp_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
